rc522_reg_sequencer: RTL and testbench

- Table-driven RC522 register sequencer; generalises the hard-coded step-by-step init into an indexed op table with NUM_OPS entries.
- Drives one 8-bit spi_master instance through its start/busy/data_in/data_out handshake.
- Executes write, read and read-modify-set-bits register operations, e.g. the antenna-on step of TxControlReg 0x14.
- Sits between the security-system top level and spi_master; reports done, error and last read value.

---
 rtl/rc522_reg_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_rc522_reg_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc522_reg_sequencer.sv
// Table-driven RC522 register sequencer over one 8-bit spi_master; per byte: load, 1-cycle strobe, busy wait, GAP_CYC gap.
// Stalls indefinitely on table/spi handshake except busy waits bounded by TIMEOUT_CYC; optional read-back verify via RC522_SEQ_VERIFY_EN.
module rc522_reg_sequencer #(
  parameter int NUM_OPS     = 16,
  parameter int IDX_W       = 4,
  parameter int GAP_CYC     = 1562500,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             go,
  output logic [IDX_W-1:0] op_idx,
  input  logic [15:0]      op_entry,
  output logic             spi_start,
  input  logic             spi_busy,
  output logic [7:0]       spi_tx,
  input  logic [7:0]       spi_rx,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_idx
);

  localparam logic [1:0] T_WRITE = 2'b00;
  localparam logic [1:0] T_READ  = 2'b01;
  localparam logic [1:0] T_END   = 2'b11;

  localparam logic [31:0]      GAP_LAST = 32'(GAP_CYC - 1);
  localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_START, S_WAITHI, S_WAITLO,
    S_GAP, S_EVAL, S_NEXT, S_DONE, S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    B_ADDR, B_DATA, B_WB_ADDR, B_WB_DATA, B_VF_ADDR, B_VF_DATA
  } byte_t;

  state_t      state;
  byte_t       phase;
  logic [31:0] cnt;
  logic        go_q;
  logic [1:0]  op_type;
  logic [5:0]  op_addr;
  logic [7:0]  op_data;
  logic [7:0]  rx_byte;
  logic [7:0]  wb_val;
`ifdef RC522_SEQ_VERIFY_EN
  logic [7:0]  vf_exp;
`endif

  logic go_rise;
  assign go_rise = go & ~go_q;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      phase     <= B_ADDR;
      cnt       <= '0;
      go_q      <= 1'b0;
      op_idx    <= '0;
      spi_start <= 1'b1;
      spi_tx    <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_idx   <= '0;
      op_type   <= '0;
      op_addr   <= '0;
      op_data   <= '0;
      rx_byte   <= '0;
      wb_val    <= '0;
`ifdef RC522_SEQ_VERIFY_EN
      vf_exp    <= '0;
`endif
    end else begin
      go_q     <= go;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (go_rise) begin
            done   <= 1'b0;
            error  <= 1'b0;
            busy   <= 1'b1;
            op_idx <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          op_type <= op_entry[15:14];
          op_addr <= op_entry[13:8];
          op_data <= op_entry[7:0];
          if (op_entry[15:14] == T_END) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            phase <= B_ADDR;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          case (phase)
            B_ADDR:    spi_tx <= {(op_type != T_WRITE), op_addr, 1'b0};
            B_DATA:    spi_tx <= (op_type == T_WRITE) ? op_data : 8'h00;
            B_WB_ADDR: spi_tx <= {1'b0, op_addr, 1'b0};
            B_WB_DATA: spi_tx <= wb_val;
            B_VF_ADDR: spi_tx <= {1'b1, op_addr, 1'b0};
            default:   spi_tx <= 8'h00;
          endcase
          spi_start <= 1'b0;
          state     <= S_START;
        end
        S_START: begin
          spi_start <= 1'b1;
          cnt       <= '0;
          state     <= S_WAITHI;
        end
        S_WAITHI: begin
          if (spi_busy) begin
            cnt   <= '0;
            state <= S_WAITLO;
          end else if (cnt >= TO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            err_idx <= op_idx;
            state   <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_WAITLO: begin
          if (!spi_busy) begin
            rx_byte <= spi_rx;
            cnt     <= '0;
            state   <= S_GAP;
          end else if (cnt >= TO_LAST) begin
            error   <= 1'b1;
            busy    <= 1'b0;
            err_idx <= op_idx;
            state   <= S_ERROR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_GAP: begin
          if (cnt >= GAP_LAST) begin
            cnt <= '0;
            case (phase)
              B_ADDR:    begin phase <= B_DATA;    state <= S_LOAD; end
              B_DATA:    state <= S_EVAL;
              B_WB_ADDR: begin phase <= B_WB_DATA; state <= S_LOAD; end
`ifdef RC522_SEQ_VERIFY_EN
              B_WB_DATA: begin vf_exp <= wb_val; phase <= B_VF_ADDR; state <= S_LOAD; end
              B_VF_ADDR: begin phase <= B_VF_DATA; state <= S_LOAD; end
              B_VF_DATA: begin
                if (rx_byte != vf_exp) begin
                  error   <= 1'b1;
                  busy    <= 1'b0;
                  err_idx <= op_idx;
                  state   <= S_ERROR;
                end else begin
                  state <= S_NEXT;
                end
              end
`endif
              default:   state <= S_NEXT;
            endcase
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_EVAL: begin
          case (op_type)
            T_WRITE: begin
`ifdef RC522_SEQ_VERIFY_EN
              vf_exp <= op_data;
              phase  <= B_VF_ADDR;
              state  <= S_LOAD;
`else
              state  <= S_NEXT;
`endif
            end
            T_READ: begin
              rd_data  <= rx_byte;
              rd_valid <= 1'b1;
              state    <= S_NEXT;
            end
            default: begin
              // SETBITS: writeback only when some mask bit is still clear
              rd_data  <= rx_byte;
              rd_valid <= 1'b1;
              if ((rx_byte & op_data) != op_data) begin
                wb_val <= rx_byte | op_data;
                phase  <= B_WB_ADDR;
                state  <= S_LOAD;
              end else begin
                state <= S_NEXT;
              end
            end
          endcase
        end
        S_NEXT: begin
          if (op_idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            op_idx <= op_idx + IDX_W'(1);
            state  <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc522_reg_sequencer.sv
// Bench for rc522_reg_sequencer: RC522 register-file slave model plus an op-table reference model
// predicting the SPI byte stream, read results and completion status for directed and random tables.
`timescale 1ns/1ps
module tb_rc522_reg_sequencer;
  localparam int NUM_OPS     = 16;
  localparam int IDX_W       = 4;
  localparam int GAP_CYC     = 3;
  localparam int TIMEOUT_CYC = 100;

  logic             CLOCK_50;
  logic             reset;
  logic             go;
  logic [IDX_W-1:0] op_idx;
  logic [15:0]      op_entry;
  logic             spi_start;
  logic             spi_busy;
  logic [7:0]       spi_tx;
  logic [7:0]       spi_rx;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] err_idx;

  logic [15:0] op_tab [NUM_OPS];
  assign op_entry = op_tab[op_idx];

  rc522_reg_sequencer #(
    .NUM_OPS(NUM_OPS), .IDX_W(IDX_W), .GAP_CYC(GAP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .go(go), .op_idx(op_idx), .op_entry(op_entry),
    .spi_start(spi_start), .spi_busy(spi_busy), .spi_tx(spi_tx), .spi_rx(spi_rx),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .error(error),
    .err_idx(err_idx)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // slave / register-file model state
  logic [7:0] regs  [64];
  logic [7:0] mreg  [64];
  int         sl_state = 0;
  int         sl_cnt   = 0;
  logic       sl_second = 1'b0;
  logic [7:0] sl_addr_byte = 8'h00;
  logic [7:0] sl_resp = 8'h00;
  logic       no_busy = 1'b0;
  logic       corrupt_en = 1'b0;
  logic [7:0] corrupt_val = 8'h00;
  logic [7:0] tx_log [$];
  int         rv_cnt = 0;

  // reference model results
  logic [7:0] exp_q [$];
  int         exp_rv;
  logic [7:0] model_rd = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk_op(input logic [1:0] t, input logic [5:0] a, input logic [7:0] d);
    return {t, a, d};
  endfunction

  // One negedge step: sample outputs, then act as spi_master + RC522.
  task automatic tick();
    @(negedge CLOCK_50);
    cyc++;
    if (!spi_start) tx_log.push_back(spi_tx);
    if (rd_valid) rv_cnt++;
    if (!reset) begin
      sl_state = 0; spi_busy = 1'b0; spi_rx = 8'h00; sl_second = 1'b0;
    end else if (sl_state == 0) begin
      if (!spi_start) begin
        if (!sl_second) begin
          sl_addr_byte = spi_tx;
          sl_resp = 8'h00;
        end else if (sl_addr_byte[7]) begin
          sl_resp = regs[sl_addr_byte[6:1]];
          if (corrupt_en) begin sl_resp = corrupt_val; corrupt_en = 1'b0; end
        end else begin
          regs[sl_addr_byte[6:1]] = spi_tx;
          sl_resp = 8'h00;
        end
        sl_second = ~sl_second;
        if (!no_busy) begin sl_cnt = int'($urandom_range(1, 3)); sl_state = 1; end
      end else if (!busy) begin
        sl_second = 1'b0;
      end
    end else if (sl_state == 1) begin
      sl_cnt--;
      if (sl_cnt <= 0) begin spi_busy = 1'b1; sl_cnt = int'($urandom_range(1, 5)); sl_state = 2; end
    end else begin
      sl_cnt--;
      if (sl_cnt <= 0) begin spi_rx = sl_resp; spi_busy = 1'b0; sl_state = 0; end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Walk the op table with the RC522 register semantics and list the bytes that must appear on SPI.
  task automatic model_run();
    logic [1:0] t;
    logic [5:0] a;
    logic [7:0] d;
    logic [7:0] v;
    exp_q.delete();
    exp_rv = 0;
    for (int i = 0; i < 64; i++) mreg[i] = regs[i];
    for (int i = 0; i < NUM_OPS; i++) begin
      t = op_tab[i][15:14]; a = op_tab[i][13:8]; d = op_tab[i][7:0];
      if (t == 2'b11) break;
      if (t == 2'b00) begin
        exp_q.push_back({1'b0, a, 1'b0}); exp_q.push_back(d);
        mreg[a] = d;
`ifdef RC522_SEQ_VERIFY_EN
        exp_q.push_back({1'b1, a, 1'b0}); exp_q.push_back(8'h00);
`endif
      end else begin
        exp_q.push_back({1'b1, a, 1'b0}); exp_q.push_back(8'h00);
        v = mreg[a];
        model_rd = v;
        exp_rv++;
        if (t == 2'b10 && ((v & d) != d)) begin
          exp_q.push_back({1'b0, a, 1'b0}); exp_q.push_back(v | d);
          mreg[a] = v | d;
`ifdef RC522_SEQ_VERIFY_EN
          exp_q.push_back({1'b1, a, 1'b0}); exp_q.push_back(8'h00);
`endif
        end
      end
    end
  endtask

  // glitch: re-pulse go and corrupt the in-flight table entry mid-run; both must be ignored.
  task automatic run_table(input bit glitch);
    bit glitched = 1'b0;
    int n = 0;
    tx_log.delete();
    rv_cnt = 0;
    go = 1'b0;
    ticks(2);
    go = 1'b1;
    tick();
    while (!(done || error) && n < 10000) begin
      if (glitch && !glitched && n > 40 && spi_busy && busy) begin
        op_tab[op_idx] = ~op_tab[op_idx];
        go = 1'b0; tick(); go = 1'b1;
        glitched = 1'b1;
      end
      tick();
      n++;
    end
    check("run_finished", {31'd0, done | error}, 32'd1);
  endtask

  task automatic compare_run(input string tag);
    check({tag, "_nbytes"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      check($sformatf("%s_b%0d", tag, i), {24'd0, tx_log[i]}, {24'd0, exp_q[i]});
    check({tag, "_done"},  {31'd0, done},  32'd1);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy},  32'd0);
    check({tag, "_rd"},    {24'd0, rd_data}, {24'd0, model_rd});
    check({tag, "_rvcnt"}, rv_cnt, exp_rv);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"},  {31'd0, spi_start}, 32'd1);
    check({tag, "_busy"},   {31'd0, busy},      32'd0);
    check({tag, "_done"},   {31'd0, done},      32'd0);
    check({tag, "_error"},  {31'd0, error},     32'd0);
    check({tag, "_rv"},     {31'd0, rd_valid},  32'd0);
    check({tag, "_rd"},     {24'd0, rd_data},   32'd0);
    check({tag, "_idx"},    {28'd0, op_idx},    32'd0);
    check({tag, "_erridx"}, {28'd0, err_idx},   32'd0);
    check({tag, "_tx"},     {24'd0, spi_tx},    32'd0);
  endtask

  task automatic clear_tab();
    for (int i = 0; i < NUM_OPS; i++) op_tab[i] = mk_op(2'b11, 6'd0, 8'd0);
  endtask

  initial begin
    int t0;
    int n;
    int nlog;
    logic [7:0] lit [$];
    reset = 1'b0; go = 1'b0; spi_busy = 1'b0; spi_rx = 8'h00;
    for (int i = 0; i < 64; i++) regs[i] = 8'h00;
    clear_tab();
    ticks(3);
    check_reset_outputs("rst_hold");
    reset = 1'b1;
    ticks(2);
    check_reset_outputs("rst_rel");

    // Init writes against an all-zero register file
    op_tab[0] = mk_op(2'b00, 6'h12, 8'h00);
    op_tab[1] = mk_op(2'b00, 6'h2A, 8'h80);
    model_run();
    run_table(1'b0);
    compare_run("wr2");
`ifndef RC522_SEQ_VERIFY_EN
    lit = '{8'h24, 8'h00, 8'h54, 8'h80};
    check("wr2_strobes", tx_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++)
      check($sformatf("wr2_lit%0d", i), {24'd0, tx_log[i]}, {24'd0, lit[i]});
`endif

    // READ TxControlReg
    clear_tab();
    regs[6'h14] = 8'h80;
    op_tab[0] = mk_op(2'b01, 6'h14, 8'h00);
    model_run();
    run_table(1'b0);
    compare_run("rd");
    check("rd_lit_b0", {24'd0, tx_log.size() > 0 ? tx_log[0] : 8'hxx}, 32'hA8);
    check("rd_val", {24'd0, rd_data}, 32'h80);
    check("rd_pulses", rv_cnt, 1);

    // SETBITS antenna-on: writeback needed, then already set
    op_tab[0] = mk_op(2'b10, 6'h14, 8'h03);
    regs[6'h14] = 8'h80;
    model_run();
    run_table(1'b0);
    compare_run("sb_wb");
    check("sb_wb_reg", {24'd0, regs[6'h14]}, 32'h83);
`ifndef RC522_SEQ_VERIFY_EN
    lit = '{8'hA8, 8'h00, 8'h28, 8'h83};
    check("sb_wb_strobes", tx_log.size(), 4);
    for (int i = 0; i < 4 && i < tx_log.size(); i++)
      check($sformatf("sb_wb_lit%0d", i), {24'd0, tx_log[i]}, {24'd0, lit[i]});
`endif
    regs[6'h14] = 8'h83;
    model_run();
    run_table(1'b0);
    compare_run("sb_nowb");
    check("sb_nowb_strobes", tx_log.size(), 2);
    check("sb_nowb_rd", {24'd0, rd_data}, 32'h83);

    // Timeout: busy never rises
    no_busy = 1'b1;
    op_tab[0] = mk_op(2'b00, 6'h12, 8'h00);
    tx_log.delete();
    go = 1'b0; ticks(2); go = 1'b1;
    n = 0;
    while (tx_log.size() == 0 && n < 200) begin tick(); n++; end
    t0 = cyc;
    n = 0;
    while (!error && n < 400) begin tick(); n++; end
    check("to_error", {31'd0, error}, 32'd1);
    check("to_latency_ok", {31'd0, ((cyc - t0) >= 95) && ((cyc - t0) <= 110)}, 32'd1);
    check("to_erridx", {28'd0, err_idx}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);
    nlog = tx_log.size();
    n = 0;
    for (int i = 0; i < 50; i++) begin tick(); if (!spi_start) n++; end
    check("to_no_strobe", n, 0);
    check("to_log", tx_log.size(), nlog);
    no_busy = 1'b0;
    model_run();
    run_table(1'b0);
    compare_run("to_restart");

    // Reset during WAITLO of op 1
    clear_tab();
    op_tab[0] = mk_op(2'b00, 6'h12, 8'h00);
    op_tab[1] = mk_op(2'b00, 6'h2A, 8'h80);
    tx_log.delete();
    go = 1'b0; ticks(2); go = 1'b1;
    n = 0;
    while (!(op_idx == 4'd1 && spi_busy) && n < 2000) begin tick(); n++; end
    check("mid_reached", {31'd0, op_idx == 4'd1 && spi_busy}, 32'd1);
    reset = 1'b0;
    go = 1'b0;
    model_rd = 8'h00;
    tick();
    check_reset_outputs("mid_rst");
    nlog = tx_log.size();
    ticks(10);
    check("mid_no_strobe", tx_log.size(), nlog);
    check_reset_outputs("mid_rst2");
    reset = 1'b1;
    ticks(2);
    check("mid_idle_idx", {28'd0, op_idx}, 32'd0);
    check("mid_idle_busy", {31'd0, busy}, 32'd0);
    model_run();
    run_table(1'b0);
    compare_run("mid_restart");

`ifdef RC522_SEQ_VERIFY_EN
    clear_tab();
    op_tab[0] = mk_op(2'b00, 6'h24, 8'h26);
    corrupt_en = 1'b1; corrupt_val = 8'h25;
    run_table(1'b0);
    check("vf_bad_error", {31'd0, error}, 32'd1);
    check("vf_bad_erridx", {28'd0, err_idx}, 32'd0);
    check("vf_bad_done", {31'd0, done}, 32'd0);
    corrupt_en = 1'b0;
    model_run();
    run_table(1'b0);
    compare_run("vf_good");
`endif

    // Random tables, random register contents, random SPI timing
    for (int r = 0; r < 18; r++) begin
      for (int i = 0; i < 64; i++) regs[i] = 8'($urandom);
      for (int i = 0; i < NUM_OPS; i++) begin
        int k;
        k = int'($urandom_range(0, 15));
        if (r == 3) k = 1 + (k % 15);
        op_tab[i] = mk_op((k == 0) ? 2'b11 : 2'(k % 3), 6'($urandom_range(0, 7)), 8'($urandom));
      end
      model_run();
      run_table(r % 4 == 1);
      compare_run($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
